// File: rtl/rpm_seg_pkg.sv
// Shared constants for the RPM seven-segment encoder: glyph bytes, FSM encoding, BCD width.
// Glyph bit map is bit0=a .. bit6=g, bit7=dp (dp always off).
package rpm_seg_pkg;

  localparam int BCD_W = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  localparam logic [7:0] GLYPH_0     = 8'h3F;
  localparam logic [7:0] GLYPH_1     = 8'h06;
  localparam logic [7:0] GLYPH_2     = 8'h5B;
  localparam logic [7:0] GLYPH_3     = 8'h4F;
  localparam logic [7:0] GLYPH_4     = 8'h66;
  localparam logic [7:0] GLYPH_5     = 8'h6D;
  localparam logic [7:0] GLYPH_6     = 8'h7D;
  localparam logic [7:0] GLYPH_7     = 8'h07;
  localparam logic [7:0] GLYPH_8     = 8'h7F;
  localparam logic [7:0] GLYPH_9     = 8'h6F;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;
  localparam logic [7:0] GLYPH_DASH  = 8'h40;

endpackage

// File: rtl/seg_glyph.sv
// BCD nibble to seven-segment glyph, combinational; blank forces an unlit digit.
// Non-decimal nibbles also render blank; output polarity follows SEG_ACTIVE_HIGH.
module seg_glyph #(
  parameter int SEG_ACTIVE_HIGH = 1
) (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [7:0] glyph
);
  import rpm_seg_pkg::*;

  logic [7:0] raw;

  always_comb begin
    raw = GLYPH_BLANK;
    if (!blank) begin
      case (nib)
        4'd0:    raw = GLYPH_0;
        4'd1:    raw = GLYPH_1;
        4'd2:    raw = GLYPH_2;
        4'd3:    raw = GLYPH_3;
        4'd4:    raw = GLYPH_4;
        4'd5:    raw = GLYPH_5;
        4'd6:    raw = GLYPH_6;
        4'd7:    raw = GLYPH_7;
        4'd8:    raw = GLYPH_8;
        4'd9:    raw = GLYPH_9;
        default: raw = GLYPH_BLANK;
      endcase
    end
    glyph = (SEG_ACTIVE_HIGH != 0) ? raw : ~raw;
  end

endmodule

// File: rtl/rpm_seg_encoder.sv
// Binary RPM to four seven-segment glyphs via serial double dabble; done VAL_W+1 edges after load.
// Loads arriving while busy park in a one-deep latest-wins slot; glyph outputs change only on done.
module rpm_seg_encoder #(
  parameter int VAL_W           = 14,
  parameter int MAX_VAL         = 9999,
  parameter int BLANK_LZ        = 1,
  parameter int SEG_ACTIVE_HIGH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [VAL_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [7:0]       seg_a,
  output logic [7:0]       seg_b,
  output logic [7:0]       seg_c,
  output logic [7:0]       seg_d
);
  import rpm_seg_pkg::*;

  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam logic [7:0] SEG_BLANK = (SEG_ACTIVE_HIGH != 0) ? GLYPH_BLANK : ~GLYPH_BLANK;
  localparam logic [7:0] SEG_DASH  = (SEG_ACTIVE_HIGH != 0) ? GLYPH_DASH  : ~GLYPH_DASH;

  logic [1:0]       state;
  logic [VAL_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;
  logic             pend_vld;
  logic [VAL_W-1:0] pend_val;
  logic             start;
  logic [VAL_W-1:0] start_val;
  logic             blank_b;
  logic             blank_c;
  logic             blank_d;
  logic [7:0]       g_a;
  logic [7:0]       g_b;
  logic [7:0]       g_c;
  logic [7:0]       g_d;

  assign busy = (state != ST_IDLE);

  // A load coinciding with UPDATE is newer than anything parked, so it goes first.
  assign start     = ((state == ST_IDLE) && load) ||
                     ((state == ST_UPDATE) && (load || pend_vld));
  assign start_val = load ? value : pend_val;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign blank_d = (BLANK_LZ != 0) && (bcd_q[15:12] == 4'd0);
  assign blank_c = blank_d && (bcd_q[11:8] == 4'd0);
  assign blank_b = blank_c && (bcd_q[7:4] == 4'd0);

  seg_glyph #(.SEG_ACTIVE_HIGH(SEG_ACTIVE_HIGH)) u_glyph_a (.nib(bcd_q[3:0]),   .blank(1'b0),    .glyph(g_a));
  seg_glyph #(.SEG_ACTIVE_HIGH(SEG_ACTIVE_HIGH)) u_glyph_b (.nib(bcd_q[7:4]),   .blank(blank_b), .glyph(g_b));
  seg_glyph #(.SEG_ACTIVE_HIGH(SEG_ACTIVE_HIGH)) u_glyph_c (.nib(bcd_q[11:8]),  .blank(blank_c), .glyph(g_c));
  seg_glyph #(.SEG_ACTIVE_HIGH(SEG_ACTIVE_HIGH)) u_glyph_d (.nib(bcd_q[15:12]), .blank(blank_d), .glyph(g_d));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt      <= '0;
      ovf_q    <= 1'b0;
      pend_vld <= 1'b0;
      pend_val <= '0;
      done     <= 1'b0;
      seg_a    <= SEG_BLANK;
      seg_b    <= SEG_BLANK;
      seg_c    <= SEG_BLANK;
      seg_d    <= SEG_BLANK;
    end else begin
      done <= 1'b0;

      if (start) begin
        bin_q <= start_val;
        bcd_q <= '0;
        cnt   <= CNT_W'(VAL_W);
        ovf_q <= (int'(start_val) > MAX_VAL);
        state <= ST_SHIFT;
      end else if (state == ST_SHIFT) begin
        {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
        cnt            <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state <= ST_UPDATE;
      end else if (state != ST_IDLE) begin
        state <= ST_IDLE;
      end

      if ((state == ST_SHIFT) && load) begin
        pend_vld <= 1'b1;
        pend_val <= value;
      end else if (state == ST_UPDATE) begin
        pend_vld <= 1'b0;
      end

      // bcd_q holds the final digits throughout UPDATE.
      if (state == ST_UPDATE) begin
        done  <= 1'b1;
        seg_a <= ovf_q ? SEG_DASH : g_a;
        seg_b <= ovf_q ? SEG_DASH : g_b;
        seg_c <= ovf_q ? SEG_DASH : g_c;
        seg_d <= ovf_q ? SEG_DASH : g_d;
      end
    end
  end

endmodule

// File: doc/rpm_seg_encoder.md
Name: rpm_seg_encoder

Overview:
- Converts a binary RPM value into four 7-segment glyph bytes that feed the display multiplexer's seg_a..seg_d inputs directly.
- Conversion is sequential shift-add-3 (double dabble), one bit per clock.
- Uses a load/busy/done handshake with a one-deep pending slot.
- Output glyphs are held stable between conversions, so the multiplexer never shows partial results.

Parameters:
- VAL_W, 14, width of the binary input; conversion takes VAL_W shift cycles.
- MAX_VAL, 9999, largest displayable value; anything above it shows the overflow pattern.
- BLANK_LZ, 1, when 1, leading zeros are blanked and the ones digit is always shown.
- SEG_ACTIVE_HIGH, 1, when 0, every output glyph bit is inverted, including the blank and reset values.

Ports:
- clk  input  1  system clock (50 MHz).
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle strobe requesting conversion of value.
- value  input  VAL_W  unsigned binary RPM, sampled on the clk edge where load=1.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; the new glyphs are valid in the same cycle.
- seg_a  output  8  ones-digit glyph.
- seg_b  output  8  tens-digit glyph.
- seg_c  output  8  hundreds-digit glyph.
- seg_d  output  8  thousands-digit glyph.

Behaviour:
- Glyph bit map: bit0=a … bit6=g, bit7=dp. dp is always 0.
- Digit glyphs (active-high): 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. Blank=0x00, dash=0x40.
- Reset (asynchronous, rst_n=0):
  - state=IDLE; busy=0; done=0; pending flag cleared.
  - seg_a..seg_d = blank.
- IDLE:
  - load=1 captures value into the shift register, clears the 16-bit BCD field and loads bit counter = VAL_W.
  - Next state is SHIFT; busy goes high on the following cycle.
- SHIFT (exactly VAL_W cycles):
  - In the same cycle, each BCD nibble >=5 gets +3, then the combined {BCD, bin} register shifts left by 1.
  - The counter decrements; when it reaches 0, go to UPDATE.
- UPDATE (1 cycle):
  - If the captured value > MAX_VAL, all four glyphs = dash.
  - Otherwise each nibble is mapped to its glyph. With BLANK_LZ=1, zero nibbles above the most significant non-zero digit become blank; seg_a is never blanked.
  - seg_* registers update; done=1 for this one cycle; busy drops to 0 in the same cycle.
  - Next state is IDLE, or SHIFT if the pending flag is set (see pending slot).
- Latency: load sampled at edge k, so seg_* change and done is high after edge k+VAL_W+1 (edge k+15 at default).
- Pending slot:
  - load while busy (SHIFT or UPDATE) stores value in a one-deep pending register and sets the pending flag.
  - A later load while the flag is set overwrites the stored value (latest wins).
  - On leaving UPDATE with the flag set, the pending value is loaded, the flag clears, and SHIFT starts directly with no IDLE cycle.
- Simultaneous load and done: the load goes to the pending slot and is converted next.
- seg_* hold their value at all times except the UPDATE edge; they never show intermediate data.
- Reset asserted mid-conversion aborts immediately to reset values, and the pending value is discarded.

Decomposition:
- Package rpm_seg_pkg:
  - glyph constants GLYPH_0..GLYPH_9, GLYPH_BLANK, GLYPH_DASH;
  - state encoding (IDLE, SHIFT, UPDATE);
  - BCD width constant (16).
- Sub-module seg_glyph:
  - combinational, 4-bit nibble plus blank flag in, 8-bit glyph out;
  - applies SEG_ACTIVE_HIGH inversion;
  - instantiated 4 times.

Test Plan:
- Reset then idle: rst_n low for 3 cycles -> seg_a..d=0x00, busy=0, done=0; nothing changes with no load.
- load, value=1234: at edge k+15, done=1 for one cycle, seg_d=0x06, seg_c=0x5B, seg_b=0x4F, seg_a=0x66; busy high for cycles k+1..k+14.
- Blanking, BLANK_LZ=1: value=7 -> seg_a=0x07, b/c/d=0x00. value=0 -> seg_a=0x3F, others 0x00. value=1005 -> 0x06,0x3F,0x3F,0x6D (d..a).
- Overflow: value=10000 and value=16383 -> all four glyphs=0x40. value=9999 -> all 0x6F.
- Pending: load 42, then load 100 and load 250 mid-conversion -> done for 42 (0x66,0x5B), then SHIFT starts immediately and done for 250 after 15 more cycles; 100 is never displayed.
- Reset mid-SHIFT (cycle 7) with a pending load -> outputs blank, busy=0; no done pulse follows after reset release.
